// File: rtl/pwm_peripheral.sv
// PWM peripheral: 16 chip outputs, each forced low, forced high, or driven by one
// shared 8-bit PWM waveform whose duty is double-buffered and applied at period wrap.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 32'd13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PRE_W = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 32'd1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_active_q, duty_active_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q, period_start_d;
  logic [15:0]      en_out_s, en_pwm_s;
  logic             tick_s, wrap_s, pwm_raw_s;

  // Next-state logic for prescaler, PWM counter, duty buffer and outputs
  always_comb begin
    en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    tick_s   = (pre_cnt_q == PRE_LAST);
    wrap_s   = tick_s && (pwm_cnt_q == 8'hFF);

    if (tick_s) begin
      pre_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
      pwm_cnt_d = pwm_cnt_q;
    end

    if (wrap_s) begin
      duty_active_d = pwm_duty_cycle;
    end else begin
      duty_active_d = duty_active_q;
    end

    period_start_d = wrap_s;

    // Compare on the next-state counter/duty so the first high clk of a period
    // lands in the same cycle as period_start.
    if (duty_active_d == 8'hFF) begin
      pwm_raw_s = 1'b1;
    end else begin
      pwm_raw_s = (pwm_cnt_d < duty_active_d);
    end

    out_d = en_out_s & (~en_pwm_s | {16{pwm_raw_s}});
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= 8'h00;
      duty_active_q  <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_active_q  <= duty_active_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers written over SPI: output enables, PWM-mode enables and duty cycle.
- Drives the 16 chip outputs.
- Each output is forced low, forced high, or driven by one shared 8-bit PWM waveform.
- Duty-cycle updates are double-buffered and applied only at period boundaries, so no runt or glitch pulses occur.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step. Legal range 1..65535. PWM period = 256*PRESCALE clk cycles (3004 Hz at 10 MHz).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- en_reg_out_7_0  input  8  output enable, bits 7:0
- en_reg_out_15_8  input  8  output enable, bits 15:8
- en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0
- en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8
- pwm_duty_cycle  input  8  requested duty (0x00 = 0%, 0xFF = 100%)
- out  output  16  chip outputs, registered
- period_start  output  1  one-clk pulse coincident with PWM counter wrap 255->0

Behaviour:
- Reset (rst_n low, async) clears:
  - prescaler count and pwm_cnt to 0
  - duty_active to 0x00
  - out to 0x0000 and period_start to 0
- Reset takes priority at any time, including mid-period; counting restarts from 0 on release.
- Prescaler: pre_cnt counts 0..PRESCALE-1, then wraps.
  - tick is asserted in the cycle where pre_cnt == PRESCALE-1.
  - PRESCALE=1: tick every cycle.
  - pre_cnt width = clog2(PRESCALE), minimum 1 bit.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255->0 with no dead cycle.
- Duty double-buffer: on the tick where pwm_cnt == 255:
  - duty_active <= pwm_duty_cycle
  - period_start <= 1 for exactly one clk
- Changes to pwm_duty_cycle at any other time have no effect until the next wrap.
- Raw waveform, combinational:
  - pwm_raw = 1 if duty_active == 0xFF
  - otherwise pwm_raw = (pwm_cnt < duty_active)
  - Consequences: 0x00 gives constant low; 0xFF gives constant high (no 1-step low gap); duty D gives high time D*PRESCALE clks per period.
- Per-bit output, registered every clk:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_raw : 1) : 0
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}
- Latency:
  - enable-register change to out: 1 clk
  - pwm_cnt change to out: 1 clk
  - period_start and out high-phase start are aligned in the same cycle (both registered from the wrap tick).
- en_pwm[i] with en_out[i]=0 gives low (output enable dominates).
- All PWM-mode outputs are phase-aligned; no per-channel offset.
- Simultaneous duty change and wrap tick: the value present on pwm_duty_cycle in that cycle is captured.
- Enable inputs are taken as synchronous to clk (the SPI block registers them in this clock domain); no synchronisers here.

Test Plan:
1. Assert rst_n low mid-period with en_out=0xFFFF -> out=0x0000 and period_start=0 immediately (no clk edge needed); after release, first period_start occurs 256*13=3328 clks later.
2. en_out=0xFFFF, en_pwm=0x0000, duty=0x37 -> out=0xFFFF one clk after enables applied, constant thereafter; toggling en_out to 0x0000 gives out=0x0000 the next clk.
3. PWM mode:
   - Stimulus: en_out=0x0001, en_pwm=0x0001, duty=0x80.
   - Required: from the period_start after duty was written, out[0] is high 1664 clks, then low 1664 clks, repeating at 3328 clks.
   - out[15:1]=0.
4. Duty extremes: duty=0x00 -> out[0] never high across 3 periods; duty=0xFF -> out[0] never low across 3 periods (checked every clk).
5. Mid-period update:
   - Stimulus: duty 0x40 active; write 0xC0 at pwm_cnt≈100.
   - Required: current period stays high 832 clks; next period high 2496 clks; period_start pulses exactly once per 3328 clks.
6. Mixed enables: en_out=0x00F0, en_pwm=0x0030, duty=0x40 -> out[5:4] toggle PWM (832 high / 2496 low); out[7:6]=1 constant; all other bits 0.
